// File: rtl/pmul_batch_pkg.sv
// Shared types for the point-multiplication batch sequencer.
package pmul_batch_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StWaitBusy,
        StWaitDone,
        StNext
    } state_e;

    localparam logic TrigAll = 1'b0;
    localparam logic TrigSel = 1'b1;

endpackage

// File: rtl/ecc_pmul_batch_ctrl_if.sv
// Word-serial link between the batch sequencer (master) and the point-multiplication core (slave).
interface ecc_pmul_batch_ctrl_if #(
    parameter int unsigned pWORD_WIDTH = 32,
    parameter int unsigned pWADDR      = 3
);
    logic                   core_ena;
    logic                   core_rdy;
    logic [pWADDR-1:0]      core_k_addr;
    logic [pWORD_WIDTH-1:0] core_k_din;
    logic [pWADDR-1:0]      core_rx_addr;
    logic [pWADDR-1:0]      core_ry_addr;
    logic                   core_rx_wren;
    logic                   core_ry_wren;
    logic [pWORD_WIDTH-1:0] core_rx_dout;
    logic [pWORD_WIDTH-1:0] core_ry_dout;

    modport master (
        output core_ena, core_k_din,
        input  core_rdy, core_k_addr, core_rx_addr, core_ry_addr,
        input  core_rx_wren, core_ry_wren, core_rx_dout, core_ry_dout
    );

    modport slave (
        input  core_ena, core_k_din,
        output core_rdy, core_k_addr, core_rx_addr, core_ry_addr,
        output core_rx_wren, core_ry_wren, core_rx_dout, core_ry_dout
    );

endinterface

// File: rtl/pmul_slot_ram.sv
// Simple dual-port slot memory: one write port, one registered read port (old data on collision).
module pmul_slot_ram #(
    parameter int unsigned Width     = 32,
    parameter int unsigned AddrWidth = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 we_i,
    input  logic [AddrWidth-1:0] waddr_i,
    input  logic [Width-1:0]     wdata_i,
    input  logic [AddrWidth-1:0] raddr_i,
    output logic [Width-1:0]     rdata_o
);
    localparam int unsigned Depth = 1 << AddrWidth;

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Only the read register is reset; array contents survive reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ecc_pmul_batch_ctrl.sv
// Batch sequencer: runs the point-multiplication core once per scalar slot and stores results.
module ecc_pmul_batch_ctrl
    import pmul_batch_pkg::*;
#(
    parameter int unsigned pWORD_WIDTH = 32,
    parameter int unsigned pNUM_WORDS  = 8,
    parameter int unsigned pNUM_SLOTS  = 4,
    parameter int unsigned pCNT_WIDTH  = 32,
    parameter int unsigned pWADDR      = $clog2(pNUM_WORDS),
    parameter int unsigned pSADDR      = (pNUM_SLOTS > 1) ? $clog2(pNUM_SLOTS) : 1
) (
    input  logic                   crypto_clk,
    input  logic                   reset_i,
    input  logic                   host_k_wr_i,
    input  logic [pSADDR-1:0]      host_slot_i,
    input  logic [pWADDR-1:0]      host_word_i,
    input  logic [pWORD_WIDTH-1:0] host_wdata_i,
    output logic [pWORD_WIDTH-1:0] host_rx_rdata_o,
    output logic [pWORD_WIDTH-1:0] host_ry_rdata_o,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic [pSADDR:0]        num_ops_i,
    input  logic [pCNT_WIDTH-1:0]  timeout_i,
    input  logic                   trig_mode_i,
    input  logic [pSADDR-1:0]      trig_slot_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_timeout_o,
    output logic                   aborted_o,
    output logic [pSADDR-1:0]      cur_slot_o,
    output logic [pCNT_WIDTH-1:0]  cycles_o,
    output logic                   trig_o,
    ecc_pmul_batch_ctrl_if.master  core
);
    localparam int unsigned AddrWidth = pSADDR + pWADDR;

    state_e                  state_q, state_d;
    logic [pSADDR-1:0]       slot_q, slot_d;
    logic [pSADDR:0]         num_ops_q, num_ops_d;
    logic [pCNT_WIDTH-1:0]   op_cnt_q, op_cnt_d, cnt_inc;
    logic [pCNT_WIDTH-1:0]   cycles_q, cycles_d;
    logic                    err_q, err_d, aborted_q, aborted_d, done_q, done_d;
    logic                    in_wait, ops_valid, last_slot, timed_out;
    logic                    k_we, rx_we, ry_we;
    logic [pWORD_WIDTH-1:0]  k_din;

    assign ops_valid = (num_ops_i != '0) && (32'(num_ops_i) <= pNUM_SLOTS);
    assign last_slot = (({1'b0, slot_q} + (pSADDR+1)'(1)) == num_ops_q);
    assign cnt_inc   = (op_cnt_q == '1) ? op_cnt_q : op_cnt_q + pCNT_WIDTH'(1);
    assign timed_out = in_wait && (timeout_i != '0) && (op_cnt_q == timeout_i);

    always_ff @(posedge crypto_clk) begin
        if (reset_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        num_ops_d = num_ops_q;
        op_cnt_d  = op_cnt_q;
        cycles_d  = cycles_q;
        err_d     = err_q;
        aborted_d = aborted_q;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    err_d     = 1'b0;
                    aborted_d = 1'b0;
                    if (ops_valid) begin
                        state_d   = StLaunch;
                        slot_d    = '0;
                        cycles_d  = '0;
                        num_ops_d = num_ops_i;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            StLaunch: begin
                op_cnt_d = pCNT_WIDTH'(1);
                state_d  = StWaitBusy;
            end
            StWaitBusy: begin
                op_cnt_d = cnt_inc;
                if (!core.core_rdy) state_d = StWaitDone;
            end
            StWaitDone: begin
                op_cnt_d = cnt_inc;
                if (core.core_rdy) begin
                    state_d  = StNext;
                    cycles_d = op_cnt_q;
                end
            end
            StNext: begin
                if (last_slot) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    slot_d  = slot_q + pSADDR'(1);
                    state_d = StLaunch;
                end
            end
            default: state_d = StIdle;
        endcase
        // Abort overrides timeout, which overrides a completion seen in the same cycle.
        if (timed_out) begin
            state_d  = StIdle;
            err_d    = 1'b1;
            done_d   = 1'b1;
            cycles_d = cycles_q;
        end
        if (abort_i && (state_q != StIdle)) begin
            state_d   = StIdle;
            aborted_d = 1'b1;
            err_d     = err_q;
            done_d    = 1'b1;
            cycles_d  = cycles_q;
        end
    end

    always_comb begin
        in_wait       = (state_q == StWaitBusy) || (state_q == StWaitDone);
        busy_o        = (state_q != StIdle);
        core.core_ena = (state_q == StLaunch);
        trig_o        = in_wait && ((trig_mode_i == TrigAll) || (slot_q == trig_slot_i));
        k_we          = host_k_wr_i && (state_q == StIdle);
        rx_we         = core.core_rx_wren && in_wait;
        ry_we         = core.core_ry_wren && in_wait;
    end

    always_ff @(posedge crypto_clk) begin
        if (reset_i) begin
            slot_q    <= '0;
            num_ops_q <= '0;
            op_cnt_q  <= '0;
            cycles_q  <= '0;
            err_q     <= 1'b0;
            aborted_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            slot_q    <= slot_d;
            num_ops_q <= num_ops_d;
            op_cnt_q  <= op_cnt_d;
            cycles_q  <= cycles_d;
            err_q     <= err_d;
            aborted_q <= aborted_d;
            done_q    <= done_d;
        end
    end

    assign done_o          = done_q;
    assign err_timeout_o   = err_q;
    assign aborted_o       = aborted_q;
    assign cur_slot_o      = slot_q;
    assign cycles_o        = cycles_q;
    assign core.core_k_din = k_din;

    pmul_slot_ram #(.Width(pWORD_WIDTH), .AddrWidth(AddrWidth)) u_k_ram (
        .clk_i   (crypto_clk),
        .rst_i   (reset_i),
        .we_i    (k_we),
        .waddr_i ({host_slot_i, host_word_i}),
        .wdata_i (host_wdata_i),
        .raddr_i ({slot_q, core.core_k_addr}),
        .rdata_o (k_din)
    );

    pmul_slot_ram #(.Width(pWORD_WIDTH), .AddrWidth(AddrWidth)) u_rx_ram (
        .clk_i   (crypto_clk),
        .rst_i   (reset_i),
        .we_i    (rx_we),
        .waddr_i ({slot_q, core.core_rx_addr}),
        .wdata_i (core.core_rx_dout),
        .raddr_i ({host_slot_i, host_word_i}),
        .rdata_o (host_rx_rdata_o)
    );

    pmul_slot_ram #(.Width(pWORD_WIDTH), .AddrWidth(AddrWidth)) u_ry_ram (
        .clk_i   (crypto_clk),
        .rst_i   (reset_i),
        .we_i    (ry_we),
        .waddr_i ({slot_q, core.core_ry_addr}),
        .wdata_i (core.core_ry_dout),
        .raddr_i ({host_slot_i, host_word_i}),
        .rdata_o (host_ry_rdata_o)
    );

endmodule

// File: tb/tb_ecc_pmul_batch_ctrl.sv
// Directed bench for ecc_pmul_batch_ctrl with a behavioural core and read-back scoreboards.
module tb_ecc_pmul_batch_ctrl;
    localparam int W = 32;
    localparam int WA = 3;
    localparam int SA = 2;
    localparam int CW = 32;

    logic          crypto_clk = 1'b0;
    logic          reset_i = 1'b1;
    logic          host_k_wr_i = 1'b0;
    logic [SA-1:0] host_slot_i = '0;
    logic [WA-1:0] host_word_i = '0;
    logic [W-1:0]  host_wdata_i = '0;
    logic [W-1:0]  host_rx_rdata_o, host_ry_rdata_o;
    logic          start_i = 1'b0, abort_i = 1'b0;
    logic [SA:0]   num_ops_i = '0;
    logic [CW-1:0] timeout_i = '0;
    logic          trig_mode_i = 1'b0;
    logic [SA-1:0] trig_slot_i = '0;
    logic          busy_o, done_o, err_timeout_o, aborted_o, trig_o;
    logic [SA-1:0] cur_slot_o;
    logic [CW-1:0] cycles_o;

    ecc_pmul_batch_ctrl_if #(.pWORD_WIDTH(W), .pWADDR(WA)) core ();

    ecc_pmul_batch_ctrl dut (
        .crypto_clk      (crypto_clk),
        .reset_i         (reset_i),
        .host_k_wr_i     (host_k_wr_i),
        .host_slot_i     (host_slot_i),
        .host_word_i     (host_word_i),
        .host_wdata_i    (host_wdata_i),
        .host_rx_rdata_o (host_rx_rdata_o),
        .host_ry_rdata_o (host_ry_rdata_o),
        .start_i         (start_i),
        .abort_i         (abort_i),
        .num_ops_i       (num_ops_i),
        .timeout_i       (timeout_i),
        .trig_mode_i     (trig_mode_i),
        .trig_slot_i     (trig_slot_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .err_timeout_o   (err_timeout_o),
        .aborted_o       (aborted_o),
        .cur_slot_o      (cur_slot_o),
        .cycles_o        (cycles_o),
        .trig_o          (trig_o),
        .core            (core)
    );

    initial forever #5 crypto_clk = ~crypto_clk;

    typedef struct {
        string       tag;
        logic [W-1:0] val;
    } exp_t;
    exp_t rx_q[$], ry_q[$], k_q[$];

    int checks = 0, passed = 0, failed = 0;
    int ena_cnt = 0, done_cnt = 0;
    int trig_cnt [4] = '{0, 0, 0, 0};
    bit core_hang = 1'b0;

    // Core model: rdy low for the 100 cycles after the launch cycle, results written near the end.
    initial begin
        int low_left, op_idx, cur_op;
        low_left = 0; op_idx = 0; cur_op = 0;
        core.core_rdy = 1'b1;
        core.core_rx_wren = 1'b0; core.core_ry_wren = 1'b0;
        core.core_rx_addr = '0;   core.core_ry_addr = '0;
        core.core_rx_dout = '0;   core.core_ry_dout = '0;
        forever begin
            @(negedge crypto_clk);
            core.core_rx_wren = 1'b0;
            core.core_ry_wren = 1'b0;
            if (!busy_o) begin
                core.core_rdy = 1'b1; low_left = 0; op_idx = 0;
            end else if (core.core_ena) begin
                core.core_rdy = 1'b0; low_left = 100; cur_op = op_idx; op_idx++;
            end else if (!core.core_rdy && !core_hang) begin
                if (low_left == 0) begin
                    core.core_rdy = 1'b1;
                end else begin
                    if (low_left <= 8) begin
                        core.core_rx_wren = 1'b1;
                        core.core_ry_wren = 1'b1;
                        core.core_rx_addr = WA'(low_left - 1);
                        core.core_ry_addr = WA'(low_left - 1);
                        core.core_rx_dout = W'(cur_op * 16 + low_left - 1);
                        core.core_ry_dout = W'(32'h100 + cur_op * 16 + low_left - 1);
                    end
                    low_left--;
                end
            end
        end
    end

    initial forever begin
        @(negedge crypto_clk);
        if (core.core_ena) ena_cnt++;
        if (done_o) done_cnt++;
        if (trig_o) trig_cnt[cur_slot_o]++;
    end

    function automatic logic [W-1:0] kval(int s, int w);
        return 32'hA000_0000 | W'(s << 8) | W'(w);
    endfunction

    task automatic tick();
        @(posedge crypto_clk);
        #1;
    endtask

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        assert (got === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic k_write(int s, int w, logic [W-1:0] d);
        host_k_wr_i = 1'b1; host_slot_i = SA'(s); host_word_i = WA'(w); host_wdata_i = d;
        tick();
        host_k_wr_i = 1'b0;
    endtask

    task automatic host_read(string tag, int s, int w, logic [W-1:0] erx, logic [W-1:0] ery);
        exp_t e;
        host_slot_i = SA'(s); host_word_i = WA'(w);
        rx_q.push_back('{tag, erx});
        ry_q.push_back('{tag, ery});
        tick();
        e = rx_q.pop_front(); check({e.tag, "_rx"}, 64'(host_rx_rdata_o), 64'(e.val));
        e = ry_q.pop_front(); check({e.tag, "_ry"}, 64'(host_ry_rdata_o), 64'(e.val));
    endtask

    task automatic k_read(string tag, int w, logic [W-1:0] ek);
        exp_t e;
        core.core_k_addr = WA'(w);
        k_q.push_back('{tag, ek});
        tick();
        e = k_q.pop_front(); check(e.tag, 64'(core.core_k_din), 64'(e.val));
    endtask

    task automatic start(int ops, int tmo, bit mode, int tslot);
        num_ops_i = (SA+1)'(ops); timeout_i = CW'(tmo);
        trig_mode_i = mode; trig_slot_i = SA'(tslot);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_done(string tag, int bound, output int n);
        n = 0;
        while (!done_o && n < bound) begin
            tick();
            n++;
        end
        check(tag, 64'(done_o), 64'd1);
    endtask

    initial begin
        int n, e0, d0, t0, t1, t2, t3;
        core.core_k_addr = '0;
        repeat (3) tick();
        check("rst_flags", 64'({busy_o, done_o, err_timeout_o, aborted_o, trig_o, core.core_ena}), 64'd0);
        check("rst_cycles", 64'(cycles_o), 64'd0);
        reset_i = 1'b0;
        tick();

        for (int s = 0; s < 4; s++)
            for (int w = 0; w < 8; w++) k_write(s, w, kval(s, w));

        // Scalar path latency: new address shows up only after one clock.
        k_read("k_s0w2", 2, kval(0, 2));
        core.core_k_addr = WA'(5);
        #1 check("k_latency_old", 64'(core.core_k_din), 64'(kval(0, 2)));
        k_read("k_s0w5", 5, kval(0, 5));

        // Two-op batch.
        e0 = ena_cnt; d0 = done_cnt; t0 = trig_cnt[0]; t1 = trig_cnt[1];
        start(2, 0, 1'b0, 0);
        check("launch_busy_ena", 64'({busy_o, core.core_ena}), 64'b11);
        repeat (5) tick();
        k_write(1, 4, 32'hDEAD_BEEF);
        wait_done("b2_done", 400, n);
        repeat (3) tick();
        check("b2_ena_pulses", 64'(ena_cnt - e0), 64'd2);
        check("b2_done_once", 64'(done_cnt - d0), 64'd1);
        check("b2_cycles", 64'(cycles_o), 64'd101);
        check("b2_busy_err", 64'({busy_o, err_timeout_o, aborted_o}), 64'd0);
        check("b2_trig_s0", 64'(trig_cnt[0] - t0), 64'd101);
        check("b2_trig_s1", 64'(trig_cnt[1] - t1), 64'd101);
        check("b2_cur_slot", 64'(cur_slot_o), 64'd1);
        host_read("s1w3", 1, 3, 32'h13, 32'h113);
        host_read("s0w7", 0, 7, 32'h07, 32'h107);
        k_read("k_busy_write_ignored", 4, kval(1, 4));

        // Out-of-range op counts finish immediately without launching.
        e0 = ena_cnt;
        start(0, 0, 1'b0, 0);
        check("ops0_done_busy", 64'({done_o, busy_o}), 64'b10);
        tick();
        check("ops0_after", 64'({done_o, busy_o}), 64'b00);
        start(5, 0, 1'b0, 0);
        check("ops5_done_busy", 64'({done_o, busy_o}), 64'b10);
        repeat (3) tick();
        check("bad_ops_no_ena", 64'(ena_cnt - e0), 64'd0);

        // Timeout with a hung core.
        core_hang = 1'b1;
        start(1, 50, 1'b0, 0);
        wait_done("tmo_done", 200, n);
        check("tmo_latency", 64'(n), 64'd51);
        check("tmo_flags", 64'({err_timeout_o, aborted_o, busy_o}), 64'b100);
        tick();
        core_hang = 1'b0;
        tick();
        start(1, 0, 1'b0, 0);
        check("tmo_cleared", 64'(err_timeout_o), 64'd0);
        wait_done("b1_done", 400, n);
        check("b1_cycles_err", 64'({cycles_o, err_timeout_o}), 64'({32'd101, 1'b0}));

        // Abort while idle does nothing.
        abort_i = 1'b1; tick(); abort_i = 1'b0; tick();
        check("idle_abort", 64'({aborted_o, done_o, busy_o}), 64'd0);

        // Trigger restricted to slot 2.
        t0 = trig_cnt[0]; t1 = trig_cnt[1]; t2 = trig_cnt[2]; t3 = trig_cnt[3];
        start(4, 0, 1'b1, 2);
        wait_done("b4_done", 800, n);
        check("sel_trig_s0", 64'(trig_cnt[0] - t0), 64'd0);
        check("sel_trig_s1", 64'(trig_cnt[1] - t1), 64'd0);
        check("sel_trig_s2", 64'(trig_cnt[2] - t2), 64'd101);
        check("sel_trig_s3", 64'(trig_cnt[3] - t3), 64'd0);

        // Abort in the middle of slot 1 of a 3-op batch.
        tick();
        e0 = ena_cnt;
        start(3, 0, 1'b0, 0);
        n = 0;
        while (cur_slot_o != SA'(1) && n < 500) begin
            tick();
            n++;
        end
        check("reach_slot1", 64'(cur_slot_o), 64'd1);
        repeat (10) tick();
        abort_i = 1'b1; tick(); abort_i = 1'b0;
        check("abort_flags", 64'({aborted_o, done_o, busy_o, err_timeout_o}), 64'b1100);
        repeat (150) tick();
        check("abort_no_slot2", 64'(ena_cnt - e0), 64'd2);

        // Reset in the middle of a batch.
        start(2, 0, 1'b0, 0);
        repeat (120) tick();
        reset_i = 1'b1;
        tick();
        check("midrst_flags", 64'({busy_o, done_o, err_timeout_o, aborted_o, trig_o, core.core_ena}), 64'd0);
        check("midrst_slot_cycles", 64'({cur_slot_o, cycles_o}), 64'd0);
        check("midrst_data", 64'({host_rx_rdata_o, host_ry_rdata_o}) | 64'(core.core_k_din), 64'd0);
        reset_i = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/ecc_pmul_batch_ctrl.md
Name: ecc_pmul_batch_ctrl

Overview:
- Word-serial batch sequencer between the register interface and a point-multiplication core (curve_mul_256 or a wider successor).
- Holds pNUM_SLOTS scalars and runs the core once per slot, back to back.
- Stores each slot's Rx/Ry result words and measures per-operation cycle count.
- Raises a capture trigger on all operations or on one selected slot, and aborts on timeout or host abort.

Parameters:
pWORD_WIDTH, 32, core word width
pNUM_WORDS, 8, words per operand (256/32)
pNUM_SLOTS, 4, scalar/result slots per batch
pCNT_WIDTH, 32, cycle/timeout counter width
pWADDR, $clog2(pNUM_WORDS), word address width
pSADDR, $clog2(pNUM_SLOTS), slot index width (min 1)

Ports:
crypto_clk  in  1  sole clock
reset_i  in  1  synchronous active-high reset
host_k_wr_i  in  1  write scalar word
host_slot_i  in  pSADDR  slot for write/read
host_word_i  in  pWADDR  word for write/read
host_wdata_i  in  pWORD_WIDTH  scalar word data
host_rx_rdata_o  out  pWORD_WIDTH  Rx[host_slot][host_word], 1-cycle latency
host_ry_rdata_o  out  pWORD_WIDTH  Ry[host_slot][host_word], 1-cycle latency
start_i  in  1  batch start pulse
abort_i  in  1  abort pulse
num_ops_i  in  pSADDR+1  operations in batch, sampled at start
timeout_i  in  pCNT_WIDTH  per-op cycle limit, 0 = disabled
trig_mode_i  in  1  0 = trigger every op, 1 = selected slot only
trig_slot_i  in  pSADDR  selected trigger slot
busy_o  out  1  batch in progress
done_o  out  1  one-cycle pulse at batch end
err_timeout_o  out  1  sticky, cleared by next start
aborted_o  out  1  sticky, cleared by next start
cur_slot_o  out  pSADDR  slot currently running
cycles_o  out  pCNT_WIDTH  cycle count of last op
trig_o  out  1  capture trigger
core_ena_o  out  1  core start pulse
core_rdy_i  in  1  core idle/ready
core_k_addr_i  in  pWADDR  core scalar word address
core_k_din_o  out  pWORD_WIDTH  scalar word, registered, 1-cycle latency
core_rx_addr_i, core_ry_addr_i  in  pWADDR  core result word addresses
core_rx_wren_i, core_ry_wren_i  in  1  core result write enables
core_rx_dout_i, core_ry_dout_i  in  pWORD_WIDTH  core result data

Behaviour:
- Reset: all outputs 0; state IDLE; all sticky flags cleared.
- Memory contents are not reset.
- States:
  - IDLE -> LAUNCH on start_i when num_ops_i in 1..pNUM_SLOTS. On entry: slot=0, cycles=0, clear flags, latch num_ops.
  - start_i with num_ops_i=0 or >pNUM_SLOTS: done_o next cycle, no launch.
  - LAUNCH: core_ena_o=1 for exactly one cycle; op counter cleared to 1; -> WAIT_BUSY.
  - WAIT_BUSY -> WAIT_DONE when core_rdy_i=0.
  - WAIT_DONE -> NEXT when core_rdy_i=1; cycles_o <= op counter.
  - NEXT: if slot==num_ops-1 -> IDLE with done_o; else slot+1 -> LAUNCH.
- Op counter increments every cycle in WAIT_BUSY/WAIT_DONE and saturates at all-ones.
- Timeout: in WAIT_BUSY/WAIT_DONE, if timeout_i!=0 and counter==timeout_i: err_timeout_o=1, done_o, -> IDLE.
- Abort: abort_i in any non-IDLE state: aborted_o=1, done_o, -> IDLE.
  - Abort has priority over timeout; timeout has priority over normal completion in the same cycle.
  - Abort in IDLE is ignored.
- start_i while busy_o is ignored.
- busy_o = state != IDLE.
- trig_o is high in WAIT_BUSY/WAIT_DONE when trig_mode_i=0, or when trig_mode_i=1 and cur_slot==trig_slot_i. Low otherwise.
- Core scalar read: core_k_din_o <= K[cur_slot][core_k_addr_i] every cycle.
- Core result writes land in Rx/Ry[cur_slot] only in WAIT_BUSY/WAIT_DONE; otherwise ignored.
- Host scalar writes are ignored while busy_o=1.
- Host reads are allowed at any time. A same-cycle core write to the same location returns old data.

Decomposition:
- Shared package pmul_batch_pkg: state enum (IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, NEXT) and the TRIG_ALL/TRIG_SEL constants.
- One natural sub-module, pmul_slot_ram: a simple dual-port memory of pNUM_SLOTS*pNUM_WORDS words, 1-cycle read. Instantiated three times, for K, Rx and Ry.

Test Plan:
- Load 2 scalars; behavioural core drops rdy 1 cycle after ena, raises it 100 cycles later, writes Rx/Ry=slot*16+word. Start with num_ops=2 -> 2 ena pulses; done once; cycles_o=101; host reads slot1 word3 = 0x13.
- num_ops=0 -> done_o 1 cycle after start, core_ena_o never asserted, busy_o stays 0.
- timeout_i=50, core never raises rdy -> err_timeout_o=1 with done_o at op counter 50; next start clears err.
- trig_mode=1, trig_slot=2, num_ops=4 -> trig_o high only while cur_slot_o=2.
- abort_i mid-slot 1 of 3 -> aborted_o=1, done_o, IDLE; slot 2 never launched. Reset mid-batch -> all outputs 0 next cycle.
- Host K write during busy ignored (readback via core k path unchanged). core_k_din_o follows core_k_addr_i with 1-cycle latency.
